// File: rtl/mult_seq_controller_if.sv
// Handshake bundle between the multiply sequencer (master) and the host/datapath side (slave).
interface mult_seq_controller_if #(
  parameter int ADDR_W = 4
);
  logic              start, abort;
  logic              lzd_a_done, lzd_b_done;
  logic              shift_a_done, shift_b_done, add_done;
  logic              mul_done, rshift_done;
  logic              ld_a, ld_b, lzd_en, shift_en, add_en, mul_en, rshift_en, write_en;
  logic [ADDR_W-1:0] addr;
  logic              write_file, done, busy, error;
  logic [2:0]        err_phase;

  modport master (
    input  start, abort, lzd_a_done, lzd_b_done, shift_a_done, shift_b_done,
           add_done, mul_done, rshift_done,
    output ld_a, ld_b, lzd_en, shift_en, add_en, mul_en, rshift_en, write_en,
           addr, write_file, done, busy, error, err_phase
  );

  modport slave (
    output start, abort, lzd_a_done, lzd_b_done, shift_a_done, shift_b_done,
           add_done, mul_done, rshift_done,
    input  ld_a, ld_b, lzd_en, shift_en, add_en, mul_en, rshift_en, write_en,
           addr, write_file, done, busy, error, err_phase
  );
endinterface

// File: rtl/mult_seq_controller.sv
// Walks N_ELEMS operand pairs through load/LZD/normalise/multiply/rshift/write, then flushes.
// Define MULT_SEQ_TIMEOUT_EN to build the per-phase watchdog, ERR state and error reporting.
module mult_seq_controller #(
  parameter int N_ELEMS     = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mult_seq_controller_if.master bus
);

  if (N_ELEMS < 1 || N_ELEMS > (1 << ADDR_W) || TIMEOUT_CYC < 2 ||
      (1 << TO_W) <= TIMEOUT_CYC) begin : g_bad_cfg
    $error("mult_seq_controller: illegal parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_LOAD, S_LZD, S_SHIFT_ADD, S_MUL, S_RSHIFT,
    S_WRITE, S_NEXT, S_FLUSH, S_DONE
`ifdef MULT_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [2:0]        phase;

  // Wait-phase code doubles as the err_phase value and the watchdog enable.
  always_comb begin
    phase = 3'd0;
    case (state)
      S_LZD:       phase = 3'd1;
      S_SHIFT_ADD: phase = 3'd2;
      S_MUL:       phase = 3'd3;
      S_RSHIFT:    phase = 3'd4;
      default:     phase = 3'd0;
    endcase
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd_cnt;
  logic            wd_exp;
  logic            error_q;
  logic [2:0]      err_phase_q;

  assign wd_exp = (phase != 3'd0) && (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    case (state)
      S_IDLE:      if (bus.start) state_nx = S_ARM;
      S_ARM:       if (!bus.start) begin
                     state_nx = S_LOAD;
                     addr_nx  = '0;
                   end
      S_LOAD:      state_nx = S_LZD;
      S_LZD:       if (bus.lzd_a_done && bus.lzd_b_done) state_nx = S_SHIFT_ADD;
      S_SHIFT_ADD: if (bus.shift_a_done && bus.shift_b_done && bus.add_done)
                     state_nx = S_MUL;
      S_MUL:       if (bus.mul_done) state_nx = S_RSHIFT;
      S_RSHIFT:    if (bus.rshift_done) state_nx = S_WRITE;
      S_WRITE:     state_nx = S_NEXT;
      S_NEXT:      if (addr == ADDR_W'(N_ELEMS - 1)) state_nx = S_FLUSH;
                   else begin
                     state_nx = S_LOAD;
                     addr_nx  = addr + ADDR_W'(1);
                   end
      S_FLUSH:     state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
`ifdef MULT_SEQ_TIMEOUT_EN
      S_ERR:       if (bus.start) state_nx = S_ARM;
`endif
      default:     state_nx = S_IDLE;
    endcase
`ifdef MULT_SEQ_TIMEOUT_EN
    // A wait state that is not leaving this cycle has its done condition false.
    if (wd_exp && state_nx == state) state_nx = S_ERR;
`endif
    if (bus.abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      addr_nx  = '0;
    end
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     wd_cnt <= '0;
    else if (phase == 3'd0 || state_nx != state)    wd_cnt <= '0;
    else                                            wd_cnt <= wd_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q     <= 1'b0;
      err_phase_q <= 3'd0;
    end else if (state_nx == S_ERR && state != S_ERR) begin
      error_q     <= 1'b1;
      err_phase_q <= phase;
    end else if (state == S_ERR && state_nx == S_ARM) begin
      error_q     <= 1'b0;
      err_phase_q <= 3'd0;
    end
  end

  assign bus.busy      = (state != S_IDLE) && (state != S_ERR);
  assign bus.error     = error_q;
  assign bus.err_phase = err_phase_q;
`else
  assign bus.busy      = (state != S_IDLE);
  assign bus.error     = 1'b0;
  assign bus.err_phase = 3'd0;
`endif

  assign bus.ld_a       = (state == S_LOAD);
  assign bus.ld_b       = (state == S_LOAD);
  assign bus.lzd_en     = (state == S_LZD);
  assign bus.shift_en   = (state == S_SHIFT_ADD);
  assign bus.add_en     = (state == S_SHIFT_ADD);
  assign bus.mul_en     = (state == S_MUL);
  assign bus.rshift_en  = (state == S_RSHIFT);
  assign bus.write_en   = (state == S_WRITE);
  assign bus.write_file = (state == S_FLUSH);
  assign bus.done       = (state == S_DONE);
  assign bus.addr       = addr;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller: phase-level trace model plus hand-computed run totals.
module tb_mult_seq_controller;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int TO = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mult_seq_controller_if #(.ADDR_W(AW)) bus();

  mult_seq_controller #(.N_ELEMS(N), .ADDR_W(AW), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic ld_a, ld_b, lzd, sh, add, mul, rsh, wr, wf, dn, busy, err;
    logic [2:0]    ep;
    logic [AW-1:0] addr;
  } ov_t;

  typedef enum {PH_IDLE, PH_ARM, PH_LOAD, PH_LZD, PH_SA, PH_MUL, PH_RS,
                PH_WR, PH_NEXT, PH_FLUSH, PH_DONE, PH_ERR} ph_t;

  ov_t act;
  assign act = {bus.ld_a, bus.ld_b, bus.lzd_en, bus.shift_en, bus.add_en, bus.mul_en,
                bus.rshift_en, bus.write_en, bus.write_file, bus.done, bus.busy,
                bus.error, bus.err_phase, bus.addr};

  int checks = 0, errors = 0;
  ov_t exp_q[$];
  int  idx, n_wr, n_wf, n_done, n_mul, done_at, last_addr;
  int  wr_addr[$];

  // Done responders: each done rises once its enable has been high for d_* prior cycles.
  int  d_lzd = 0, d_sa = 0, d_mul = 0, d_rs = 0;
  int  c_lzd = 0, c_sa = 0, c_mul = 0, c_rs = 0;
  bit  tie1 = 1'b0;
  always @(posedge clk) begin
    c_lzd <= bus.lzd_en    ? c_lzd + 1 : 0;
    c_sa  <= bus.add_en    ? c_sa  + 1 : 0;
    c_mul <= bus.mul_en    ? c_mul + 1 : 0;
    c_rs  <= bus.rshift_en ? c_rs  + 1 : 0;
  end
  assign bus.lzd_a_done   = tie1 || (bus.lzd_en && c_lzd >= d_lzd);
  assign bus.lzd_b_done   = tie1 || bus.lzd_en;
  assign bus.shift_a_done = tie1 || bus.shift_en;
  assign bus.shift_b_done = tie1 || bus.shift_en;
  assign bus.add_done     = tie1 || (bus.add_en && c_sa >= d_sa);
  assign bus.mul_done     = tie1 || (bus.mul_en && c_mul >= d_mul);
  assign bus.rshift_done  = tie1 || (bus.rshift_en && c_rs >= d_rs);

  function automatic ov_t expect_of(ph_t p, int a);
    ov_t o = '0;
    o.addr = AW'(a);
    o.busy = !(p inside {PH_IDLE, PH_ERR});
    case (p)
      PH_LOAD:  begin o.ld_a = 1'b1; o.ld_b = 1'b1; end
      PH_LZD:   o.lzd = 1'b1;
      PH_SA:    begin o.sh = 1'b1; o.add = 1'b1; end
      PH_MUL:   o.mul = 1'b1;
      PH_RS:    o.rsh = 1'b1;
      PH_WR:    o.wr  = 1'b1;
      PH_FLUSH: o.wf  = 1'b1;
      PH_DONE:  o.dn  = 1'b1;
      PH_ERR:   begin o.err = 1'b1; o.ep = 3'd4; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic push(input ph_t p, input int a, input int cnt = 1);
    for (int k = 0; k < cnt; k++) exp_q.push_back(expect_of(p, a));
  endtask

  // Expected per-cycle trace from the ARM cycle onward; ab = element aborted in MUL,
  // wd = element 0 never finishes RSHIFT.
  task automatic build(input int n, input int ab, input bit wd);
    push(PH_ARM, last_addr);
    for (int e = 0; e < n; e++) begin
      push(PH_LOAD, e);
      push(PH_LZD, e, tie1 ? 1 : d_lzd + 1);
      push(PH_SA,  e, tie1 ? 1 : d_sa + 1);
      if (e == ab) begin
        push(PH_MUL, e);
        push(PH_IDLE, 0, 3);
        last_addr = 0;
        return;
      end
      push(PH_MUL, e, tie1 ? 1 : d_mul + 1);
      if (wd) begin
        push(PH_RS, e, TO);
        push(PH_ERR, e, 3);
        last_addr = e;
        return;
      end
      push(PH_RS, e, tie1 ? 1 : d_rs + 1);
      push(PH_WR, e);
      push(PH_NEXT, e);
    end
    push(PH_FLUSH, n - 1);
    push(PH_DONE, n - 1);
    push(PH_IDLE, n - 1);
    last_addr = n - 1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic compare_loop();
    ov_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        idx++;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL trace[%0d]: got %h expected %h", idx, act, e);
        end
        if (act.wr) begin n_wr++; wr_addr.push_back(int'(act.addr)); end
        if (act.wf) n_wf++;
        if (act.mul) n_mul++;
        if (act.dn) begin n_done++; done_at = idx; end
      end
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    #1;
    chk("trace_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_run(input int n, input int ab, input bit wd);
    int b;
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    n_wr = 0; n_wf = 0; n_done = 0; n_mul = 0; done_at = -1; idx = -1;
    wr_addr.delete();
    build(n, ab, wd);
    if (ab >= 0) begin
      b = 0;
      while (!(bus.mul_en && int'(bus.addr) == ab) && b < 500) begin
        @(negedge clk);
        b++;
      end
      chk("abort_reach_mul", b < 500, 1);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    int b;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    last_addr = 0;
    fork compare_loop(); join_none

    #2 rst_n = 1'b0;
    #1 chk("reset_values", act, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All dones tied high.
    tie1 = 1'b1;
    do_run(N, -1, 1'b0);
    tie1 = 1'b0;
    chk("t1_write_count", n_wr, 4);
    for (int i = 0; i < 4; i++) chk("t1_write_addr", (i < wr_addr.size()) ? wr_addr[i] : -1, i);
    chk("t1_write_file", n_wf, 1);
    chk("t1_done_count", n_done, 1);
    chk("t1_done_at", done_at, 30);

    // Multiply takes 6 cycles per element.
    d_mul = 5;
    do_run(N, -1, 1'b0);
    chk("t2_done_at", done_at, 50);
    chk("t2_mul_cycles", n_mul, 24);

    // Abort in MUL of element 2, then a clean run.
    d_mul = 2;
    do_run(N, 2, 1'b0);
    chk("abort_no_done", n_done, 0);
    chk("abort_no_wfile", n_wf, 0);
    chk("abort_busy", act.busy, 0);
    chk("abort_addr", act.addr, 0);
    d_mul = 0;
    do_run(N, -1, 1'b0);
    chk("post_abort_done_at", done_at, 30);
    chk("post_abort_writes", n_wr, 4);

`ifdef MULT_SEQ_TIMEOUT_EN
    d_rs = 100000;
    do_run(N, -1, 1'b1);
    chk("wd_error", act.err, 1);
    chk("wd_err_phase", act.ep, 4);
    chk("wd_busy", act.busy, 0);
    d_rs = 0;
    do_run(N, -1, 1'b0);
    chk("wd_rearm_done_at", done_at, 30);
    chk("wd_rearm_error", act.err, 0);
    d_sa = 7;
    do_run(N, -1, 1'b0);
    chk("wd_edge_done_at", done_at, 58);
    chk("wd_edge_error", act.err, 0);
    d_sa = 0;
`endif

    // Asynchronous reset in the middle of SHIFT_ADD.
    d_sa = 3;
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    b = 0;
    while (!bus.shift_en && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("rst_reach_shift", b < 100, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk("rst_async_values", act, 0);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_held_ignores_start", act, 0);
    rst_n = 1'b1;
    last_addr = 0;
    @(negedge clk);
    chk("rst_release_arm_busy", act.busy, 1);
    d_sa = 0;
    do_run(N, -1, 1'b0);
    chk("rst_post_done_at", done_at, 30);
    chk("rst_post_writes", n_wr, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
